// File: rtl/jtag_ram64_loader_if.sv
// jtag_ram64_loader_if: stream, RAM scan-chain and CPU write-port signals of the loader
// Ports: in_* source stream, out_* sink stream, ram_j* chain shift port,
//        cpu_wen/ram_wen CPU write request and gated RAM write enable.
interface jtag_ram64_loader_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             ram_jen;
    logic [WIDTH-1:0] ram_jin;
    logic [WIDTH-1:0] ram_jout;
    logic             cpu_wen;
    logic             ram_wen;

    modport master (
        output in_valid, in_data, out_ready, ram_jout, cpu_wen,
        input  in_ready, out_valid, out_data, ram_jen, ram_jin, ram_wen
    );

    modport slave (
        input  in_valid, in_data, out_ready, ram_jout, cpu_wen,
        output in_ready, out_valid, out_data, ram_jen, ram_jin, ram_wen
    );
endinterface

// File: rtl/jtag_ram64_loader.sv
// jtag_ram64_loader: one pass shifts DEPTH words into the RAM chain while dumping the displaced words
// Ports: clk/rst_n clock and async active-low reset; i_start/i_abort pass control;
//        o_busy/o_done/o_cpu_stall/o_shift_count status; bus carries streams, chain and write port.
module jtag_ram64_loader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_cpu_stall,
    output logic [CNT_W-1:0] o_shift_count,
    jtag_ram64_loader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_stall;
    logic [CNT_W-1:0] r_cnt;
    logic             w_run;
    logic             w_xfer;
    logic             w_last;

    // abort wins over a transfer, so the handshake is withdrawn on that cycle as well
    assign w_run  = (r_state == SHIFT) & ~i_abort;
    assign w_xfer = w_run & bus.in_valid & bus.out_ready;
    assign w_last = r_cnt == CNT_W'(DEPTH - 1);

    // combinational from async-reset state so the chain stops the moment reset asserts
    assign bus.ram_jen   = w_xfer;
    assign bus.in_ready  = w_run & bus.out_ready;
    assign bus.out_valid = w_run & bus.in_valid;
    assign bus.ram_jin   = bus.in_data;
    assign bus.out_data  = bus.ram_jout;
    assign bus.ram_wen   = bus.cpu_wen & (r_state == IDLE);

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_cpu_stall   = r_stall;
    assign o_shift_count = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_stall <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: if (i_start) begin
                    r_state <= SHIFT;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                    r_stall <= 1'b1;
                end
                SHIFT: if (i_abort) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_stall <= 1'b0;
                end else if (w_xfer) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_stall <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_stall <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_jtag_ram64_loader.sv
// tb_jtag_ram64_loader: directed passes against a chained RAM model with a sink scoreboard
module tb_jtag_ram64_loader;
    localparam int W  = 32;
    localparam int D  = 64;
    localparam int CW = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          busy;
    logic          done;
    logic          stall;
    logic [CW-1:0] cnt;

    always #5 clk = ~clk;

    jtag_ram64_loader_if #(.WIDTH(W)) bus ();

    jtag_ram64_loader #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (start),
        .i_abort       (abort),
        .o_busy        (busy),
        .o_done        (done),
        .o_cpu_stall   (stall),
        .o_shift_count (cnt),
        .bus           (bus.slave)
    );

    logic [W-1:0] mem [D];
    logic [W-1:0] snap [D];
    bit           mem_init = 1'b0;
    logic [W-1:0] q [$];
    int           checks = 0;
    int           errors = 0;
    int           n_jen = 0;
    int           n_done = 0;
    int           k = 0;
    int           last_cycles = 0;
    int           nd;

    assign bus.ram_jout = mem[D-1];

    // RAM chain: Jin -> word0 ... word63 -> Jout
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < D; i++) mem[i] <= W'(1000 + i);
            mem_init <= 1'b1;
        end else if (bus.ram_jen) begin
            for (int i = D - 1; i > 0; i--) mem[i] <= mem[i-1];
            mem[0] <= bus.ram_jin;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.ram_jen) n_jen++;
        if (done) n_done++;
        if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) chk("sink_extra", 1, 0);
            else chk("sink_data", bus.out_data, q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_pass();
        snap = mem;
        start = 1'b1;
        #1;
        chk("start_ram_wen", bus.ram_wen, bus.cpu_wen);
        chk("start_busy_low", busy, 0);
        tick();
        start = 1'b0;
        chk("pass_busy", busy, 1);
        chk("pass_stall", stall, 1);
        chk("pass_cnt0", cnt, 0);
        k = 0;
    endtask

    task automatic shift_n(input int n, input bit bp);
        int got = 0;
        int cyc = 0;
        bit orr = 1'b1;
        while (got < n && cyc < 500) begin
            bus.in_valid  = 1'b1;
            bus.in_data   = W'(D - 1 - k);
            bus.out_ready = bp ? orr : 1'b1;
            orr = ~orr;
            #1;
            if (!bus.out_ready) begin
                chk("bp_jen", bus.ram_jen, 0);
                chk("bp_in_ready", bus.in_ready, 0);
            end else begin
                q.push_back(snap[D-1-k]);
                k++;
                got++;
            end
            tick();
            cyc++;
        end
        chk("shift_timeout", got, n);
        last_cycles = cyc;
    endtask

    task automatic finish_pass();
        chk("done_pulse", done, 1);
        chk("done_stall", stall, 1);
        chk("done_jen", bus.ram_jen, 0);
        chk("done_ram_wen", bus.ram_wen, 0);
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("done_clear", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_stall", stall, 0);
        chk("cnt_hold_depth", cnt, D);
    endtask

    initial begin
        bus.in_valid  = 1'b1;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        bus.cpu_wen   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_stall", stall, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_jen", bus.ram_jen, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b1;
        tick();
        bus.cpu_wen = 1'b1;
        #1;
        chk("idle_ram_wen", bus.ram_wen, 1);

        // pass 1: no stalls, CPU write held high from IDLE through DONE
        begin_pass();
        chk("shift_ram_wen", bus.ram_wen, 0);
        shift_n(D, 1'b0);
        chk("consecutive", last_cycles, D);
        chk("jen_count1", n_jen, D);
        finish_pass();
        chk("idle_ram_wen2", bus.ram_wen, 1);
        bus.cpu_wen = 1'b0;
        for (int a = 0; a < D; a++) chk("mem_pass1", mem[a], a);

        // pass 2: sink back-pressure every other cycle
        begin_pass();
        shift_n(D, 1'b1);
        chk("bp_cycles", last_cycles, 2 * D - 1);
        finish_pass();
        chk("jen_count2", n_jen, 2 * D);
        for (int a = 0; a < D; a++) chk("mem_pass2", mem[a], a);

        // pass 3: source bubble at shift_count 10
        begin_pass();
        shift_n(10, 1'b0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (5) begin
            #1;
            chk("bubble_out_valid", bus.out_valid, 0);
            chk("bubble_jen", bus.ram_jen, 0);
            chk("bubble_cnt", cnt, 10);
            tick();
        end
        shift_n(D - 10, 1'b0);
        finish_pass();

        // pass 4: abort with a transfer pending at shift_count 20
        begin_pass();
        shift_n(20, 1'b0);
        nd = n_done;
        abort = 1'b1;
        #1;
        chk("abort_jen", bus.ram_jen, 0);
        tick();
        abort = 1'b0;
        bus.in_valid = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_stall", stall, 0);
        chk("abort_cnt", cnt, 20);
        repeat (3) tick();
        chk("abort_no_done", n_done, nd);
        chk("abort_cnt_hold", cnt, 20);

        // pass 5: asynchronous reset at shift_count 30
        begin_pass();
        shift_n(30, 1'b0);
        #1;
        chk("pre_rst_jen", bus.ram_jen, 1);
        rst_n = 1'b0;
        #1;
        chk("async_jen", bus.ram_jen, 0);
        chk("async_busy", busy, 0);
        chk("async_stall", stall, 0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_cnt", cnt, 0);
        chk("post_rst_done", done, 0);
        chk("post_rst_busy", busy, 0);

        tick();
        chk("queue_empty", q.size(), 0);
        chk("done_total", n_done, 3);
        chk("jen_total", n_jen, 3 * D + 20 + 30);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/jtag_ram64_loader.md
Name: jtag_ram64_loader

Overview:
Sequencer for the 64-word JTAG-chained RAM scan path. It streams 64 words from a valid/ready source into the RAM's shift chain using the chain enable and chain input. At the same time it streams the 64 displaced words from the chain output to a valid/ready sink, so a single pass both loads and dumps memory. While a pass runs, the block also arbitrates the RAM write port, stalling CPU-side writes.

Parameters:
WIDTH, 32, data word width (the RAM word width)
DEPTH, 64, number of words in the chain; shift count per pass
CNT_W, 7, counter width; must be at least clog2(DEPTH)+1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse that begins a load/dump pass; sampled only in IDLE
abort  input  1  terminates a pass in progress; no done pulse
in_valid  input  1  source word available
in_data  input  WIDTH  source word
in_ready  output  1  source word accepted this cycle
out_valid  output  1  displaced word available to sink
out_data  output  WIDTH  displaced word
out_ready  input  1  sink can accept
ram_jen  output  1  chain shift enable to RAM
ram_jin  output  WIDTH  chain input to RAM
ram_jout  input  WIDTH  chain output from RAM (last word of chain)
cpu_wen  input  1  CPU write request
ram_wen  output  1  gated write enable to RAM
cpu_stall  output  1  CPU must hold its write; high whenever not IDLE
busy  output  1  pass in progress (SHIFT state)
done  output  1  one-cycle pulse after the final shift
shift_count  output  CNT_W  shifts completed in the current pass

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state IDLE, shift_count 0, done 0, busy 0, cpu_stall 0, ram_jen 0, in_ready 0, out_valid 0. ram_wen follows cpu_wen. ram_jin and out_data are combinational pass-throughs.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 moves to SHIFT next cycle and clears shift_count.
  - ram_wen = cpu_wen.
  - A cpu_wen and start in the same cycle: the write goes through, and SHIFT begins next cycle.
- SHIFT:
  - busy=1, cpu_stall=1, ram_wen=0.
  - xfer = in_valid & out_ready.
  - ram_jen = xfer, in_ready = out_ready, out_valid = in_valid.
  - ram_jin = in_data, out_data = ram_jout.
  - Each xfer cycle shifts the chain once and increments shift_count.
  - The xfer that brings shift_count to DEPTH moves the block to DONE.
  - A stall on either side holds the chain; no shift occurs.
- DONE: done=1 for exactly one cycle, cpu_stall=1, ram_jen=0; the next state is always IDLE. shift_count holds DEPTH until the next start.
- Data ordering:
  - Chain order is Jin → word0 … word63 → Jout.
  - The k-th word accepted (k=0..63) ends at address 63−k, so the source must send the highest address first.
  - The k-th word emitted is the old contents of address 63−k.
- abort:
  - In SHIFT, abort has priority over xfer: ram_jen=0 that cycle, next state IDLE, no done.
  - shift_count holds its partial value.
  - RAM contents are partially rotated; this is the caller's responsibility.
  - abort in IDLE or DONE is ignored.
- start outside IDLE is ignored; no queuing.
- Asynchronous reset mid-pass forces IDLE immediately, and ram_jen drops without waiting for a clock. RAM contents are not cleared by this block.
- shift_count never exceeds DEPTH and never wraps.

Test Plan:
- Full pass, no stalls: start; source sends 63,62,…,0 with in_valid=1 and out_ready=1 → 64 consecutive ram_jen cycles. done pulses on the cycle after the 64th shift. RAM address a reads a. Sink receives the prior contents in order addr 63→0.
- Back-pressure: out_ready toggled 1,0,1,0 during SHIFT → ram_jen=0 and in_ready=0 on every out_ready=0 cycle. Exactly 64 shifts total; data is identical to the unstalled pass.
- Source bubbles: in_valid low for 5 cycles at shift_count=10 → no shift, shift_count holds at 10, out_valid=0 throughout.
- Arbitration: cpu_wen=1 during SHIFT and DONE → ram_wen=0 and cpu_stall=1. The same cpu_wen in IDLE → ram_wen=1. cpu_wen and start together in IDLE → write occurs, busy rises on the next cycle.
- Abort: abort with xfer at shift_count=20 → no shift that cycle, IDLE next, done never pulses, shift_count=20. A new start then clears it to 0.
- Reset mid-pass: rst_n low at shift_count=30 → ram_jen, busy and cpu_stall fall asynchronously. After release: IDLE, shift_count=0, done=0.
